// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the boot-time instruction loader.
//   loader_state_e : loader FSM state encoding
//   LEN_W          : width of the word-count header
//   IMEM_BASE      : byte address of instruction word 0 (the core's reset PC)
package mips_pkg;

  localparam int LEN_W = 16;

  localparam logic [31:0] IMEM_BASE = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles big-endian 32-bit words from a byte stream.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : synchronous restart (drops any partial word)
//   enable       : a byte is accepted this cycle
//   byte_in      : accepted byte
//   last_byte    : the next accepted byte completes a word (byte counter == 3)
//   word_valid   : one-cycle pulse, the cycle after the completing byte
//   word_data    : last completed word; held until the next one completes
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  byte_cnt_q;
  // Only bytes 0..2 of the word in flight are buffered; the fourth byte goes
  // straight into word_data, so the completed word is available one cycle
  // after its last byte and stays stable while the next word fills.
  logic [23:0] shift_q;

  assign last_byte = (byte_cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      word_valid <= 1'b0;
      word_data  <= 32'd0;
    end else if (clear) begin
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= enable && last_byte;
      if (enable) begin
        shift_q    <= {shift_q[15:0], byte_in};
        byte_cnt_q <= byte_cnt_q + 2'd1;
        if (last_byte) begin
          word_data <= {shift_q, byte_in};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader in front of the instruction memory.
// Parses a byte stream (16-bit big-endian word count, then big-endian 32-bit
// instructions), writes the words to consecutive word addresses from
// IMEM_BASE, and holds the core in reset until the load is complete.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready : byte stream input
//   load_req        : restart request, honoured in DONE or ERR only
//   imem_we/imem_addr/imem_wdata : instruction memory write port
//   cpu_hold        : drives the core's active-high reset
//   busy            : load in progress (LEN_HI, LEN_LO, DATA, FLUSH)
//   err             : header count exceeded DEPTH (held until load_req)
//   words_loaded    : words written by the current load
//   state_dbg       : current FSM state, for observation
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready depends only on the state register, never on
// in_valid, so the source may present data without waiting for ready and
// must hold in_data/in_valid until the transfer edge.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int LEN_W = mips_pkg::LEN_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    load_req,
  output logic                    imem_we,
  output logic [31:0]             imem_addr,
  output logic [31:0]             imem_wdata,
  output logic                    cpu_hold,
  output logic                    busy,
  output logic                    err,
  output logic [LEN_W-1:0]        words_loaded,
  output mips_pkg::loader_state_e state_dbg
);

  import mips_pkg::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  loader_state_e    state_q;
  loader_state_e    state_d;
  logic [7:0]       len_hi_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_full;
  logic [LEN_W-1:0] words_loaded_q;
  logic [IDX_W-1:0] word_idx_q;
  logic [31:0]      addr_q;

  logic accept;
  logic restart;
  logic pk_enable;
  logic pk_last_byte;
  logic pk_word_valid;
  logic [31:0] pk_word_data;
  logic word_done;
  logic last_word;

  assign accept    = in_valid && in_ready;
  assign restart   = load_req && ((state_q == ST_DONE) || (state_q == ST_ERR));
  assign len_full  = LEN_W'({len_hi_q, in_data});
  assign pk_enable = accept && (state_q == ST_DATA);
  assign word_done = pk_enable && pk_last_byte;
  // The word completing now is the len-th one.
  assign last_word = word_done && ((words_loaded_q + 1'b1) == len_q);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (restart),
    .enable     (pk_enable),
    .byte_in    (in_data),
    .last_byte  (pk_last_byte),
    .word_valid (pk_word_valid),
    .word_data  (pk_word_data)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LEN_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LEN_HI: if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_full == '0)                      state_d = ST_DONE;
          else if (len_full > LEN_W'(DEPTH))       state_d = ST_ERR;
          else                                     state_d = ST_DATA;
        end
      end
      ST_DATA:   if (last_word) state_d = ST_FLUSH;
      // FLUSH covers the cycle the final write is on the bus, so the core
      // is only released once memory holds the whole program.
      ST_FLUSH:  state_d = ST_DONE;
      ST_DONE,
      ST_ERR:    if (load_req) state_d = ST_LEN_HI;
      default:   state_d = ST_LEN_HI;
    endcase
  end

  // Output logic (Moore, decoded from the state register)
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    cpu_hold = 1'b1;
    err      = 1'b0;
    case (state_q)
      ST_LEN_HI, ST_LEN_LO, ST_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_FLUSH: busy     = 1'b1;
      ST_DONE:  cpu_hold = 1'b0;
      ST_ERR:   err      = 1'b1;
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Header, address and progress registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_hi_q       <= 8'd0;
      len_q          <= '0;
      word_idx_q     <= '0;
      words_loaded_q <= '0;
      addr_q         <= IMEM_BASE;
    end else if (restart) begin
      word_idx_q     <= '0;
      words_loaded_q <= '0;
    end else begin
      if (accept && (state_q == ST_LEN_HI)) len_hi_q <= in_data;
      if (accept && (state_q == ST_LEN_LO)) len_q    <= len_full;
      if (word_done) begin
        // Address is registered alongside the packed word so both appear
        // together in the write cycle and hold until the next write.
        addr_q         <= IMEM_BASE + 32'({word_idx_q, 2'b00});
        word_idx_q     <= word_idx_q + 1'b1;
        words_loaded_q <= words_loaded_q + 1'b1;
      end
    end
  end

  assign imem_we      = pk_word_valid;
  assign imem_wdata   = pk_word_data;
  assign imem_addr    = addr_q;
  assign words_loaded = words_loaded_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle MIPS core's instruction memory. Accepts a byte stream (valid/ready) containing a 16-bit word count followed by big-endian 32-bit instructions, packs the bytes into words, and writes them into instruction memory at consecutive word addresses from 0. It holds the core in reset until the load completes, then releases it so execution starts at PC 0. It can be re-armed to reload a new program without a system reset.

## Interface
Parameters:
- DEPTH, 64, instruction memory size in words; legal counts are 0..DEPTH.
- LEN_W, 16, width of the word-count header.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both 1 at the edge.
- load_req  in  1  single-cycle restart request; honoured only in DONE or ERR.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  32  byte address of the write: word_idx × 4, so bits [1:0] are always 0.
- imem_wdata  out  32  instruction word.
- cpu_hold  out  1  1 holds the core in reset; the core's active-high reset is driven from this.
- busy  out  1  1 in LEN_HI, LEN_LO, DATA, FLUSH.
- err  out  1  sticky error: header count exceeded DEPTH.
- words_loaded  out  LEN_W  number of words written so far.

## Operation
- States: LEN_HI, LEN_LO, DATA, FLUSH, DONE, ERR.
- LEN_HI: accept byte → len[15:8] → LEN_LO.
- LEN_LO: accept byte → len[7:0]. Go to DONE if the count is 0, ERR if the count is > DEPTH, otherwise DATA.
- DATA: bytes fill the word MSB first. Byte 0 → [31:24], byte 3 → [7:0]; a 2-bit byte counter tracks position.
  - On the 4th byte, the write is issued on the next cycle. word_idx and words_loaded increment.
  - When that word is the len-th, the next state is FLUSH; otherwise the FSM stays in DATA.
- FLUSH: one cycle; in_ready = 0; then DONE.
- DONE: cpu_hold = 0, in_ready = 0; stream input is ignored.
- ERR: cpu_hold = 1, in_ready = 0, err = 1; stream input is ignored.
- load_req in DONE or ERR → LEN_HI next cycle. That cycle also sets cpu_hold = 1, clears err, words_loaded, word_idx and the byte counter. Memory contents are left untouched.
- load_req in any other state is ignored.
- in_ready = 1 exactly in LEN_HI, LEN_LO and DATA.
- Arithmetic:
  - word_idx is log2(DEPTH) bits; it never wraps because count ≤ DEPTH is guaranteed.
  - words_loaded is LEN_W bits; len compares as unsigned.

## Timing
- Reset values: state LEN_HI, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, busy 1, err 0, words_loaded 0, in_ready 1.
- Reset mid-load: abort immediately; the next load restarts from the header.
- Byte throughput: one byte per cycle, no bubbles, including across word boundaries.
- Write latency: 4th byte accepted at edge N → imem_we = 1 with valid addr/wdata during cycle N+1 only.
- Between writes: imem_we = 0; addr/wdata hold their last values.
- Release: final byte at edge N → write during cycle N+1 (state FLUSH) → DONE and cpu_hold = 0 from cycle N+2. The core never runs while a write is pending.
- Zero count: LEN_LO byte at edge N → DONE and cpu_hold = 0 from N+1, with no writes.
- Oversize count: LEN_LO byte at edge N → ERR and err = 1 from N+1.
- load_req at edge M in DONE: cpu_hold = 1 and busy = 1 from M+1. in_valid in the same cycle is not consumed.

## Structure
- Shared package mips_pkg holds:
  - the loader state enum;
  - LEN_W;
  - the IMEM_BASE = 0 constant.
- One sub-module is natural: byte_packer.
  - Holds the 2-bit byte counter and the 32-bit shift register.
  - Emits word_valid for one cycle with the packed word.
  - Has clear and enable inputs.
- The FSM, address counter and output registers stay in imem_loader.

## Test plan
- Count 2, stream 0x00 0x02 0x20 0x08 0x00 0x05 0xAC 0x01 0x00 0x04, in_valid held high:
  - imem_we pulses twice, with (0x00000000, 0x20080005) then (0x00000004, 0xAC010004);
  - cpu_hold falls 2 cycles after the last byte;
  - words_loaded = 2.
- Same stream with in_valid toggling randomly: identical writes and final state; no byte is lost or duplicated.
- Header 0x00 0x00: no imem_we; cpu_hold = 0 one cycle after the second byte.
- Header with count DEPTH+1 (0x00 0x41 at DEPTH = 64):
  - ERR state, err = 1, cpu_hold stays 1, in_ready = 0;
  - then load_req followed by a valid 1-word stream → err = 0, one write, release.
- Reset:
  - Assert reset after 6 bytes of a 3-word load: outputs return to reset values asynchronously.
  - A fresh 1-word load then writes address 0.
- In DONE, pulse load_req together with in_valid = 1: the byte is not consumed, cpu_hold = 1 next cycle, and the following bytes are parsed as a new header.
